// File: rtl/sub_result_display_pkg.sv
// Shared constants for the subtractor result display.
// Contents:
//   - Active-low seven-segment codes, bit order {g,f,e,d,c,b,a}.
//   - Active-low anode patterns, one per digit position.
//   - The 4-bit digit-select encoding: 0-9 are decimal digits,
//     10 is minus and 15 is blank.
package sub_result_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    localparam logic [3:0] SEL_MINUS = 4'd10;
    localparam logic [3:0] SEL_BLANK = 4'd15;

    function automatic logic [3:0] an_pattern(input logic [1:0] idx);
        case (idx)
            2'd0:    an_pattern = AN_DIG0;
            2'd1:    an_pattern = AN_DIG1;
            2'd2:    an_pattern = AN_DIG2;
            default: an_pattern = AN_DIG3;
        endcase
    endfunction

endpackage

// File: rtl/sub_result_display_seg7_decode.sv
// Combinational digit-select to seven-segment decoder.
// Ports:
//   sel_i : 4-bit digit-select code (0-9 digits, 10 minus, others blank)
//   seg_o : active-low segment pattern {g,f,e,d,c,b,a}
module seg7_decode
    import sub_result_display_pkg::*;
(
    input  logic [3:0] sel_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (sel_i)
            4'd0:      seg_o = SEG_0;
            4'd1:      seg_o = SEG_1;
            4'd2:      seg_o = SEG_2;
            4'd3:      seg_o = SEG_3;
            4'd4:      seg_o = SEG_4;
            4'd5:      seg_o = SEG_5;
            4'd6:      seg_o = SEG_6;
            4'd7:      seg_o = SEG_7;
            4'd8:      seg_o = SEG_8;
            4'd9:      seg_o = SEG_9;
            SEL_MINUS: seg_o = SEG_MINUS;
            default:   seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sub_result_display.sv
// Captures the BCD subtractor's magnitude and sign, and shows the result on a
// 4-digit multiplexed common-anode seven-segment display.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load_i     : single-cycle strobe capturing mag_i / positive_i
//   mag_i      : magnitude 0-15
//   positive_i : 1 = non-negative result, 0 = negative
//   an         : active-low anodes, an[0] is the rightmost digit
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point, always off
//   valid_o    : set once a load has been captured since reset
module sub_result_display
    import sub_result_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] mag_i,
    input  logic       positive_i,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       valid_o
);

    logic [3:0]       held_mag_q;
    logic             held_pos_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;

    logic             wrap;
    logic             tens;
    logic [3:0]       units;
    logic [3:0]       sel_d;
    logic [6:0]       seg_d;

    assign wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    // Magnitude never exceeds 15, so the tens digit is at most 1.
    assign tens  = (held_mag_q >= 4'd10);
    assign units = tens ? (held_mag_q - 4'd10) : held_mag_q;

    always_comb begin
        sel_d = SEL_BLANK;
        if (!valid_q) begin
            sel_d = SEL_MINUS;
        end else begin
            case (idx_q)
                2'd0:    sel_d = units;
                2'd1:    sel_d = tens ? 4'd1 : SEL_BLANK;
                // A negative zero is shown without a minus sign.
                2'd2:    sel_d = (!held_pos_q && held_mag_q != 4'd0) ? SEL_MINUS : SEL_BLANK;
                default: sel_d = SEL_BLANK;
            endcase
        end
    end

    seg7_decode u_decode (
        .sel_i (sel_d),
        .seg_o (seg_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            held_mag_q <= 4'd0;
            held_pos_q <= 1'b1;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
                idx_q <= idx_q + 2'd1;
            end
            if (load_i) begin
                held_mag_q <= mag_i;
                held_pos_q <= positive_i;
                valid_q    <= 1'b1;
            end
            // Output registers follow the pre-edge index and held values.
            an_q  <= an_pattern(idx_q);
            seg_q <= seg_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = 1'b1;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_sub_result_display.sv
module tb_sub_result_display;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_i;
    logic [3:0] mag_i;
    logic       positive_i;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       valid_o;

    always #5 clk = ~clk;

    sub_result_display #(.REFRESH_DIV(RD), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_i),
        .mag_i      (mag_i),
        .positive_i (positive_i),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .valid_o    (valid_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what has been loaded and how many edges since reset.
    bit m_valid = 1'b0;
    int m_mag   = 0;
    bit m_pos   = 1'b1;
    int m_k     = 0;

    localparam logic [6:0] T_MINUS = 7'b0111111;
    localparam logic [6:0] T_BLANK = 7'b1111111;

    function automatic logic [6:0] digit_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return T_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int dig);
        if (!m_valid) return T_MINUS;
        case (dig)
            0: return digit_code(m_mag % 10);
            1: return (m_mag >= 10) ? digit_code(1) : T_BLANK;
            2: return (!m_pos && m_mag != 0) ? T_MINUS : T_BLANK;
            default: return T_BLANK;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input bit rst, input bit ld, input int mag, input bit pos);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic [3:0] one;
        int dig;
        one        = 4'b0001;
        reset      = rst;
        load_i     = ld;
        mag_i      = 4'(mag);
        positive_i = pos;
        @(posedge clk);
        if (rst) begin
            e_an    = 4'b1111;
            e_seg   = T_BLANK;
            m_valid = 1'b0;
            m_mag   = 0;
            m_pos   = 1'b1;
            m_k     = 0;
        end else begin
            dig   = (m_k / RD) % 4;
            e_an  = ~(one << dig);
            e_seg = exp_seg(dig);
            if (ld) begin
                m_valid = 1'b1;
                m_mag   = mag;
                m_pos   = pos;
            end
            m_k++;
        end
        #1;
        chk("an", {3'b000, an}, {3'b000, e_an});
        chk("seg", seg, e_seg);
        chk("dp", {6'd0, dp}, 7'd1);
        chk("valid", {6'd0, valid_o}, {6'd0, m_valid});
        load_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        bit found;
        reset = 1'b1; load_i = 1'b0; mag_i = 4'd0; positive_i = 1'b1;

        // 1: reset, then an idle scan showing minus on every digit
        tick(1'b1, 1'b0, 0, 1'b1);
        tick(1'b1, 1'b0, 0, 1'b1);
        idle(17);

        // 2: positive single digit
        tick(1'b0, 1'b1, 7, 1'b1);
        idle(17);

        // 3: negative two-digit result
        tick(1'b0, 1'b1, 12, 1'b0);
        idle(17);

        // 4: negative zero shows plain 0
        tick(1'b0, 1'b1, 0, 1'b0);
        idle(17);

        // 5: back-to-back loads, last wins
        tick(1'b0, 1'b1, 3, 1'b1);
        tick(1'b0, 1'b1, 15, 1'b0);
        idle(17);

        // 6: reset with simultaneous load while digit 2 is showing
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_k >= 1 && (((m_k - 1) / RD) % 4) == 2) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        chk("reach_dig2", {6'd0, found}, 7'd1);
        tick(1'b1, 1'b1, 9, 1'b0);
        idle(17);

        // Randomized loads and occasional resets
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
